// File: rtl/data_route_pkg.sv
// Shared data_route parameters: default word width, pack ratio and derived beat width.
package data_route_pkg;

  localparam int unsigned DR_IN_W  = 128;
  localparam int unsigned DR_RATIO = 12;
  localparam int unsigned DR_OUT_W = DR_IN_W * DR_RATIO;

endpackage : data_route_pkg

// File: rtl/data_pack.sv
// Packs RATIO input words (word 0 at LSB) into one wide output beat.
// Define DATA_PACK_TLAST_EN to add tlast ports and flush partial beats on tlast.
module data_pack
  import data_route_pkg::*;
#(
  parameter int unsigned IN_W  = DR_IN_W,
  parameter int unsigned RATIO = DR_RATIO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       s_in_tdata,
  input  logic                  s_in_tvalid,
`ifdef DATA_PACK_TLAST_EN
  input  logic                  s_in_tlast,
`endif
  output logic                  s_in_tready,
  output logic [IN_W*RATIO-1:0] m_out_tdata,
  output logic                  m_out_tvalid,
`ifdef DATA_PACK_TLAST_EN
  output logic                  m_out_tlast,
`endif
  input  logic                  m_out_tready
);

  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] beat_c;
  logic             in_last_c;
  logic             beat_end_c;
  logic             accept_c;

`ifdef DATA_PACK_TLAST_EN
  logic             last_q, last_d;
  assign in_last_c = s_in_tlast;
`else
  assign in_last_c = 1'b0;
`endif

  // The word finishing a beat may only enter when the output register can take it.
  assign beat_end_c  = (cnt_q == LAST_CNT) | in_last_c;
  assign s_in_tready = rst_n & (~beat_end_c | ~valid_q | m_out_tready);
  assign accept_c    = s_in_tvalid & s_in_tready;

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    beat_c  = acc_q;
`ifdef DATA_PACK_TLAST_EN
    last_d  = last_q;
`endif
    for (int k = 0; k < int'(RATIO); k++) begin
      if (cnt_q == CNT_W'(k)) beat_c[k*IN_W +: IN_W] = s_in_tdata;
    end

    if (valid_q && m_out_tready) valid_d = 1'b0;

    // Accumulator is cleared after each beat so flushed beats carry zero upper slots.
    if (accept_c) begin
      if (beat_end_c) begin
        data_d  = beat_c;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
`ifdef DATA_PACK_TLAST_EN
        last_d  = in_last_c;
`endif
      end else begin
        acc_d = beat_c;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef DATA_PACK_TLAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef DATA_PACK_TLAST_EN
      last_q  <= last_d;
`endif
    end
  end

  assign m_out_tdata  = data_q;
  assign m_out_tvalid = valid_q;
`ifdef DATA_PACK_TLAST_EN
  assign m_out_tlast  = last_q;
`endif

endmodule : data_pack

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack: driver feeds a packing model, monitor checks emitted beats.
module tb_data_pack;

  localparam int unsigned IN_W  = 128;
  localparam int unsigned RATIO = 12;
  localparam int unsigned OUT_W = IN_W * RATIO;

  typedef struct {
    logic [IN_W-1:0] data;
    logic            last;
    int              gap;
  } stim_t;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  s_in_tdata;
  logic             s_in_tvalid;
  logic             s_in_tready;
  logic [OUT_W-1:0] m_out_tdata;
  logic             m_out_tvalid;
  logic             m_out_tready;
`ifdef DATA_PACK_TLAST_EN
  logic             s_in_tlast;
  logic             m_out_tlast;
`endif

  data_pack #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_in_tdata   (s_in_tdata),
    .s_in_tvalid  (s_in_tvalid),
`ifdef DATA_PACK_TLAST_EN
    .s_in_tlast   (s_in_tlast),
`endif
    .s_in_tready  (s_in_tready),
    .m_out_tdata  (m_out_tdata),
    .m_out_tvalid (m_out_tvalid),
`ifdef DATA_PACK_TLAST_EN
    .m_out_tlast  (m_out_tlast),
`endif
    .m_out_tready (m_out_tready)
  );

  always #5 clk = ~clk;

  stim_t           stim_q[$];
  exp_t            exp_q[$];
  logic [IN_W-1:0] model_words[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              acc_cnt = 0;
  int              beats_seen = 0;
  bit              drv_busy = 1'b0;
  int              rdy_mode = 1;

  function automatic logic [IN_W-1:0] slot(input logic [OUT_W-1:0] b, input int k);
    return b[k*IN_W +: IN_W];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic push_word(input logic [IN_W-1:0] d, input logic last, input int gap);
    stim_t s;
    s.data = d; s.last = last; s.gap = gap;
    stim_q.push_back(s);
  endtask

  // Reference packer: collects accepted words and emits the beat it expects.
  task automatic model_accept(input stim_t s);
    exp_t e;
    model_words.push_back(s.data);
    if (model_words.size() == RATIO || s.last) begin
      e.data = '0;
      for (int k = 0; k < model_words.size(); k++) e.data[k*IN_W +: IN_W] = model_words[k];
      e.last = s.last;
      exp_q.push_back(e);
      model_words.delete();
    end
  endtask

  // Driver
  initial begin
    stim_t s;
    bit    ok;
    int    n;
    s_in_tvalid = 1'b0;
    s_in_tdata  = '0;
`ifdef DATA_PACK_TLAST_EN
    s_in_tlast  = 1'b0;
`endif
    forever begin
      if (stim_q.size() == 0) begin
        s_in_tvalid = 1'b0;
        @(posedge clk); #1;
      end else begin
        drv_busy = 1'b1;
        s = stim_q.pop_front();
        repeat (s.gap) begin
          s_in_tvalid = 1'b0;
          @(posedge clk); #1;
        end
        s_in_tvalid = 1'b1;
        s_in_tdata  = s.data;
`ifdef DATA_PACK_TLAST_EN
        s_in_tlast  = s.last;
`endif
        n = 0;
        forever begin
          @(negedge clk);
          ok = s_in_tready;
          @(posedge clk); #1;
          if (ok) break;
          n++;
          if (n > 400) break;
        end
        if (ok) begin
          acc_cnt++;
          model_accept(s);
        end else begin
          n_vec++; n_err++;
          $display("FAIL accept_timeout: word %h not accepted in 400 cycles", s.data);
        end
        s_in_tvalid = 1'b0;
        drv_busy = 1'b0;
      end
    end
  end

  // Downstream ready generator: 0 = stall, 1 = always ready, 2 = toggle every cycle
  initial begin
    m_out_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_out_tready = 1'b0;
        1:       m_out_tready = 1'b1;
        default: m_out_tready = ~m_out_tready;
      endcase
    end
  end

  // Monitor: compares every handshaked beat with the scoreboard head
  initial begin
    exp_t e;
    int   bad;
    forever begin
      @(negedge clk);
      if (rst_n && m_out_tvalid && m_out_tready) begin
        beats_seen++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: beat %0d slot0 %h, expected no beat", beats_seen, slot(m_out_tdata, 0));
        end else begin
          e = exp_q.pop_front();
          bad = -1;
          for (int k = 0; k < RATIO; k++)
            if (bad < 0 && slot(m_out_tdata, k) !== slot(e.data, k)) bad = k;
          if (bad >= 0) begin
            n_err++;
            $display("FAIL beat_data: beat %0d slot %0d got %h expected %h",
                     beats_seen, bad, slot(m_out_tdata, bad), slot(e.data, bad));
          end
`ifdef DATA_PACK_TLAST_EN
          n_vec++;
          if (m_out_tlast !== e.last) begin
            n_err++;
            $display("FAIL beat_tlast: beat %0d got %b expected %b", beats_seen, m_out_tlast, e.last);
          end
`endif
        end
      end
    end
  end

  task automatic wait_acc(input int target);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (acc_cnt >= target) return;
    end
    n_vec++; n_err++;
    $display("FAIL wait_acc: accepted %0d words, expected %0d", acc_cnt, target);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (stim_q.size() == 0 && !drv_busy && exp_q.size() == 0) return;
    end
    n_vec++; n_err++;
    $display("FAIL drain_timeout: %0d stimuli and %0d beats outstanding", stim_q.size(), exp_q.size());
  endtask

  initial begin
    int base;
    int beats0;
    rst_n = 1'b0;
    #3;
    chk("rst_tready", 128'(s_in_tready), 128'd0);
    chk("rst_tvalid", 128'(m_out_tvalid), 128'd0);
    chk("rst_tdata_zero", 128'(m_out_tdata == '0), 128'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous stream, ready high: two beats, check output latency
    base = acc_cnt;
    for (int i = 1; i <= 24; i++) push_word(IN_W'(i), 1'b0, 0);
    wait_acc(base + 11);
    chk("latency_before_word12", 128'(m_out_tvalid), 128'd0);
    wait_acc(base + 12);
    chk("latency_after_word12", 128'(m_out_tvalid), 128'd1);
    chk("beat0_slot0", slot(m_out_tdata, 0), 128'h1);
    chk("beat0_slot11", slot(m_out_tdata, 11), 128'hC);
    wait_drained();

    // Downstream stall for 30 cycles after beat0, then release
    rdy_mode = 0;
    @(posedge clk); #2;
    base = acc_cnt;
    for (int i = 1; i <= 24; i++) push_word(IN_W'(32'h200 + i), 1'b0, 0);
    wait_acc(base + 12);
    repeat (30) begin
      @(posedge clk); #2;
      chk("stall_tvalid", 128'(m_out_tvalid), 128'd1);
      chk("stall_hold", 128'(m_out_tdata == exp_q[0].data), 128'd1);
    end
    chk("stall_accepted", 128'(acc_cnt - base), 128'd23);
    chk("stall_tready", 128'(s_in_tready), 128'd0);
    rdy_mode = 1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("b2b_word24_in", 128'(acc_cnt - base), 128'd24);
    chk("b2b_tvalid", 128'(m_out_tvalid), 128'd1);
    chk("b2b_beat1_slot0", slot(m_out_tdata, 0), 128'h20D);
    wait_drained();

    // Toggling ready with random input gaps: 120 words -> 10 beats
    beats0 = beats_seen;
    rdy_mode = 2;
    for (int i = 0; i < 120; i++)
      push_word({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, int'($urandom_range(0, 2)));
    wait_drained();
    chk("toggle_beats", 128'(beats_seen - beats0), 128'd10);
    rdy_mode = 1;
    @(posedge clk); #2;

    // Reset with a pending beat and a partial beat in flight
    rdy_mode = 0;
    @(posedge clk); #2;
    base = acc_cnt;
    for (int i = 1; i <= 17; i++) push_word(IN_W'(32'h300 + i), 1'b0, 0);
    wait_acc(base + 17);
    chk("pre_rst_tvalid", 128'(m_out_tvalid), 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", 128'(m_out_tvalid), 128'd0);
    chk("async_rst_tready", 128'(s_in_tready), 128'd0);
    chk("async_rst_tdata", 128'(m_out_tdata == '0), 128'd1);
    exp_q.delete();
    model_words.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 1;
    base = acc_cnt;
    for (int i = 1; i <= 12; i++) push_word(IN_W'(32'h400 + i), 1'b0, 0);
    wait_acc(base + 12);
    chk("post_rst_slot0", slot(m_out_tdata, 0), 128'h401);
    chk("post_rst_slot11", slot(m_out_tdata, 11), 128'h40C);
    wait_drained();

`ifdef DATA_PACK_TLAST_EN
    // tlast on word 5 flushes a partial beat with zeroed upper slots
    base = acc_cnt;
    for (int i = 1; i <= 5; i++) push_word(IN_W'(32'h500 + i), (i == 5), 0);
    wait_acc(base + 5);
    chk("tlast_tvalid", 128'(m_out_tvalid), 128'd1);
    chk("tlast_flag", 128'(m_out_tlast), 128'd1);
    chk("tlast_slot4", slot(m_out_tdata, 4), 128'h505);
    chk("tlast_slot5_zero", slot(m_out_tdata, 5), 128'h0);
    chk("tlast_slot11_zero", slot(m_out_tdata, 11), 128'h0);
    for (int i = 1; i <= 12; i++) push_word(IN_W'(32'h600 + i), 1'b0, 0);
    wait_acc(base + 17);
    chk("after_tlast_slot0", slot(m_out_tdata, 0), 128'h601);
    chk("after_tlast_flag", 128'(m_out_tlast), 128'd0);
    wait_drained();
`endif

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_data_pack

// File: doc/data_pack.md
DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 SHALL have parameter IN_W, default 128, meaning input word width in bits.
REQ-002 SHALL have parameter RATIO, default 12, meaning input words per output beat (output width IN_W*RATIO = 1536).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port s_in_tdata  input  IN_W  input word.
REQ-006 SHALL have port s_in_tvalid  input  1  input word valid.
REQ-007 SHALL have port s_in_tready  output  1  block accepts input word.
REQ-008 SHALL have port m_out_tdata  output  IN_W*RATIO  packed beat, feeding one data_route slave port.
REQ-009 SHALL have port m_out_tvalid  output  1  packed beat valid.
REQ-010 SHALL have port m_out_tready  input  1  downstream accepts beat.
REQ-011 SHALL have port s_in_tlast / m_out_tlast  input/output  1  frame end, present only with DATA_PACK_TLAST_EN.

Function
REQ-012 SHALL treat a transfer as occurring on a rising edge where tvalid and tready are both high.
REQ-013 SHALL write the k-th accepted word of a beat (k = 0..RATIO-1) to accumulator bits [k*IN_W +: IN_W], word 0 at LSB.
REQ-014 SHALL keep a word counter 0..RATIO-1, incrementing per accepted word and wrapping to 0 when the beat completes.
REQ-015 SHALL, on accepting word RATIO-1, copy the completed accumulator (including that word) into the output register and assert m_out_tvalid on the next cycle (latency one cycle after the last word).
REQ-016 SHALL hold m_out_tdata and m_out_tvalid stable while m_out_tvalid=1 and m_out_tready=0.
REQ-017 SHALL drive s_in_tready = (counter != RATIO-1) | ~m_out_tvalid | m_out_tready; no combinational path from s_in_tvalid to s_in_tready.
REQ-018 SHALL sustain one input word per cycle and one output beat every RATIO cycles when m_out_tready stays high.
REQ-019 SHALL, when a beat completes in the same cycle the previous beat is accepted, load the new beat with m_out_tvalid remaining high and no bubble.
REQ-020 SHALL never drop, duplicate, or reorder words; accumulator slots not yet written in the current beat are don't-care internally but never presented.

Reset
REQ-021 SHALL, on rst_n low, immediately clear counter to 0, m_out_tvalid to 0, m_out_tdata to 0, m_out_tlast to 0, discarding any partial beat.
REQ-022 SHALL hold s_in_tready at 0 while rst_n is low and deassert-synchronise nothing else; first acceptance is the first edge after rst_n rises.

Configuration
REQ-023 SHALL, with DATA_PACK_TLAST_EN defined, flush a partial beat when s_in_tlast accompanies an accepted word: zero all higher slots, emit the beat with m_out_tlast=1, reset counter to 0.
REQ-024 SHALL, with DATA_PACK_TLAST_EN defined, treat tlast on word RATIO-1 as a normal full beat with m_out_tlast=1, and use (counter==RATIO-1 | s_in_tlast) in place of counter==RATIO-1 in REQ-017.
REQ-025 SHALL, without DATA_PACK_TLAST_EN, omit both tlast ports and emit only full beats.

Structure
REQ-026 SHALL take IN_W and RATIO defaults (128, 12) and the derived OUT_W constant from the shared data_route package.
REQ-027 SHALL be a single module; counter/accumulator and output register are one always-block pair, no sub-modules.

Verification
REQ-028 SHALL test: 24 words 0x1..0x18 continuous, tready=1 -> two beats, beat0 slot0=0x1 slot11=0xC, tvalid 1 cycle after word 12.
REQ-029 SHALL test: m_out_tready=0 for 30 cycles after beat0 -> s_in_tready drops after word 23 accepted, beat0 held stable, no loss when released.
REQ-030 SHALL test: tready toggling every cycle with random s_in_tvalid gaps, 120 words -> 10 beats matching scoreboard in order.
REQ-031 SHALL test: rst_n pulled low after 5 words -> tvalid=0 immediately; next 12 words after release form beat with first word at slot0.
REQ-032 SHALL test (DATA_PACK_TLAST_EN): tlast on word 5 -> beat slots0..4 data, slots5..11 zero, m_out_tlast=1, next word lands in slot0.
REQ-033 SHALL test: beat completion coinciding with acceptance of previous beat -> m_out_tvalid stays 1, back-to-back beats, zero idle cycles.
